// File: rtl/muldiv_sequencer_if.sv
// Execute/Decode-side handshake bundle for the HI/LO multiply/divide sequencer.
// The core drives operands and qualifiers; the sequencer returns HI/LO, busy and the stall request.
interface muldiv_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             startE;
   logic [1:0]       opE;
   logic [WIDTH-1:0] srcaE;
   logic [WIDTH-1:0] srcbE;
   logic             mthiE;
   logic             mtloE;
   logic             hiloD;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             stallD;

   modport master (
      output startE, opE, srcaE, srcbE, mthiE, mtloE, hiloD,
      input  hi, lo, busy, stallD
   );

   modport slave (
      input  startE, opE, srcaE, srcbE, mthiE, mtloE, hiloD,
      output hi, lo, busy, stallD
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative shift-add multiplier / restoring divider owning the MIPS HI/LO registers.
// One result bit per cycle; operation spans IDLE -> RUN (WIDTH cycles) -> FIX -> IDLE.
module muldiv_sequencer #(
   parameter int WIDTH = 32,
   parameter int CNTW  = 6
) (
   input  logic                 clk,
   input  logic                 reset,
   muldiv_sequencer_if.slave    bus
);
   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t               state_q, state_d;
   logic [CNTW-1:0]      count_q, count_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic                 div_q, div_d;
   logic                 sgn_q, sgn_d;
   logic                 sign_a_q, sign_a_d;
   logic                 sign_b_q, sign_b_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;

   logic [WIDTH-1:0]     abs_a, abs_b;
   logic [WIDTH:0]       sum_mul, shifted, diff;
   logic [2*WIDTH-1:0]   prod;
   logic [WIDTH-1:0]     quo, rem;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         count_q  <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         div_q    <= 1'b0;
         sgn_q    <= 1'b0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         div_q    <= div_d;
         sgn_q    <= sgn_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      div_d    = div_q;
      sgn_d    = sgn_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      hi_d     = hi_q;
      lo_d     = lo_q;

      abs_a = (!bus.opE[0] && bus.srcaE[WIDTH-1]) ? -bus.srcaE : bus.srcaE;
      abs_b = (!bus.opE[0] && bus.srcbE[WIDTH-1]) ? -bus.srcbE : bus.srcbE;

      // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
      sum_mul = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
      // Divide: acc = {partial remainder, dividend bits feeding in / quotient bits shifting out}.
      shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      diff    = shifted - {1'b0, b_q};

      prod = (sgn_q && (sign_a_q ^ sign_b_q)) ? -acc_q : acc_q;
      quo  = acc_q[WIDTH-1:0];
      rem  = acc_q[2*WIDTH-1:WIDTH];
      if (sgn_q && (sign_a_q ^ sign_b_q)) quo = -quo;
      if (sgn_q && sign_a_q)              rem = -rem;
      // Zero divisor returns the dividend as originally presented, undoing the abs capture.
      if (b_q == '0) begin
         quo = '1;
         rem = (sgn_q && sign_a_q) ? -a_q : a_q;
      end

      case (state_q)
         IDLE: begin
            if (bus.startE) begin
               state_d  = RUN;
               count_d  = '0;
               a_d      = abs_a;
               b_d      = abs_b;
               div_d    = bus.opE[1];
               sgn_d    = !bus.opE[0];
               sign_a_d = !bus.opE[0] && bus.srcaE[WIDTH-1];
               sign_b_d = !bus.opE[0] && bus.srcbE[WIDTH-1];
               acc_d    = bus.opE[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
            end else begin
               if (bus.mthiE) hi_d = bus.srcaE;
               if (bus.mtloE) lo_d = bus.srcaE;
            end
         end
         RUN: begin
            if (div_q) begin
               acc_d = {(diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], ~diff[WIDTH]};
            end else begin
               acc_d = {sum_mul, acc_q[WIDTH-1:1]};
            end
            count_d = count_q + 1'b1;
            if (count_q == CNTW'(WIDTH-1)) state_d = FIX;
         end
         FIX: begin
            state_d = IDLE;
            if (div_q) begin
               hi_d = rem;
               lo_d = quo;
            end else begin
               hi_d = prod[2*WIDTH-1:WIDTH];
               lo_d = prod[WIDTH-1:0];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.hi     = hi_q;
   assign bus.lo     = lo_q;
   assign bus.busy   = (state_q != IDLE);
   assign bus.stallD = bus.hiloD & (bus.busy | bus.startE);
endmodule
